// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared types and constants for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

  // Bytes assembled into one instruction word
  localparam int BYTES_PER_WORD = 4;

  // Default number of words loaded per session
  localparam int DEFAULT_WORDS = 32;

  // Loader session state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Little-endian byte shift-in. Tracks the byte position and
//               flags the cycle in which the final byte of a word is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,          // restart at byte 0 for a new session
  input  logic        accept,         // byte handshake completes this cycle
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,      // word including this cycle's byte
  output logic        word_complete   // final byte of the word accepted
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_index_q, byte_index_d;
  logic [31:0]      word_q, word_d;

  // Place the accepted byte at its lane; partial words persist across gaps
  always_comb begin
    word_d       = word_q;
    byte_index_d = byte_index_q;
    if (clear) begin
      byte_index_d = '0;
    end else if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (byte_index_q == IDX_W'(k)) begin
          word_d[8*k +: 8] = byte_in;
        end
      end
      // Power-of-two lane count, so the increment wraps to 0 after lane 3
      byte_index_d = byte_index_q + IDX_W'(1);
    end
  end

  // Byte position and partial word registers
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_index_q <= '0;
      word_q       <= '0;
    end else begin
      byte_index_q <= byte_index_d;
      word_q       <= word_d;
    end
  end

  assign word_next     = word_d;
  assign word_complete = accept && (byte_index_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Streams program bytes into 32-bit words and writes them to
//               consecutive instruction-memory slots, one session at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int WORDS  = DEFAULT_WORDS,
  parameter int ADDR_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             byteIn,
  input  logic                   byteValid,
  output logic                   byteReady,
  output logic [ADDR_W-1:0]      writeAddress,
  output logic [31:0]            writeData,
  output logic                   writeEnable,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(WORDS):0] wordCount
);

  localparam int CNT_W = $clog2(WORDS) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_index_q, word_index_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [ADDR_W-1:0]  write_address_q, write_address_d;
  logic [31:0]        write_data_q, write_data_d;
  logic               write_enable_q, write_enable_d;
  logic               byte_ready_q, byte_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               session_clear;
  logic               byte_accept;
  logic [31:0]        asm_word;
  logic               asm_complete;

  // Handshake only counts while the loader is advertising readiness
  assign byte_accept = byteValid && byte_ready_q;

  word_assembler u_word_assembler (
    .clock         (clock),
    .reset         (reset),
    .clear         (session_clear),
    .accept        (byte_accept),
    .byte_in       (byteIn),
    .word_next     (asm_word),
    .word_complete (asm_complete)
  );

  // Next-state, counter and output computation; outputs follow the next state
  always_comb begin
    state_d         = state_q;
    word_index_d    = word_index_q;
    word_count_d    = word_count_q;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    session_clear   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_LOAD;
          word_index_d  = '0;
          word_count_d  = '0;
          session_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        // Capture address and full word as the final byte arrives so both
        // are stable for the whole write cycle and hold afterwards
        if (asm_complete) begin
          state_d         = ST_WRITE;
          write_address_d = ADDR_W'(word_index_q) << 2;
          write_data_d    = asm_word;
        end
      end
      ST_WRITE: begin
        word_index_d = word_index_q + CNT_W'(1);
        word_count_d = word_count_q + CNT_W'(1);
        state_d      = (word_index_q == CNT_W'(WORDS - 1)) ? ST_DONE : ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    byte_ready_d   = (state_d == ST_LOAD);
    write_enable_d = (state_d == ST_WRITE);
    busy_d         = (state_d == ST_LOAD) || (state_d == ST_WRITE);
    done_d         = (state_d == ST_DONE);
  end

  // Session FSM with registered outputs; reset overrides any pending start
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      word_index_q    <= '0;
      word_count_q    <= '0;
      write_address_q <= '0;
      write_data_q    <= '0;
      write_enable_q  <= 1'b0;
      byte_ready_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_index_q    <= word_index_d;
      word_count_q    <= word_count_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_enable_q  <= write_enable_d;
      byte_ready_q    <= byte_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign byteReady    = byte_ready_q;
  assign writeAddress = write_address_q;
  assign writeData    = write_data_q;
  assign writeEnable  = write_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wordCount    = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Scoreboard bench for instr_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

  localparam int WORDS  = 32;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic [ADDR_W-1:0] writeAddress;
  logic [31:0]       writeData;
  logic              writeEnable;
  logic              busy;
  logic              done;
  logic [5:0]        wordCount;

  int n_tests     = 0;
  int n_fail      = 0;
  int n_strobes   = 0;
  int exp_strobes = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];

  instr_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .byteIn       (byteIn),
    .byteValid    (byteValid),
    .byteReady    (byteReady),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .writeEnable  (writeEnable),
    .busy         (busy),
    .done         (done),
    .wordCount    (wordCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write
  always @(negedge clock) begin
    wr_t e;
    if (writeEnable === 1'b1) begin
      n_strobes++;
      if (sb.size() == 0) begin
        chk("spurious_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", writeAddress, e.addr);
        chk("wr_data", writeData, e.data);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_byteReady",   byteReady, 0);
    chk("rst_writeEnable", writeEnable, 0);
    chk("rst_busy",        busy, 0);
    chk("rst_done",        done, 0);
    chk("rst_wordCount",   wordCount, 0);
    chk("rst_writeAddr",   writeAddress, 0);
    chk("rst_writeData",   writeData, 0);
  endtask

  // Called at a negedge; returns at the negedge where the DUT sits in LOAD
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_busy",  busy, 1);
    chk("start_ready", byteReady, 1);
    chk("start_count", wordCount, 0);
    chk("start_done",  done, 0);
  endtask

  // Send nbytes of a word; inj=1 pulses start with byte 2 (LOAD),
  // inj=2 pulses start during the write cycle
  task automatic send_word(input logic [31:0] data, input logic [31:0] addr,
                           input int gap, input int inj, input int nbytes);
    int waited;
    for (int k = 0; k < nbytes; k++) begin
      waited = 0;
      while (byteReady !== 1'b1 && waited < 50) begin
        byteValid = 1'b0;
        @(negedge clock);
        waited++;
      end
      if (waited >= 50) begin
        chk("ready_timeout", 0, 1);
        byteValid = 1'b0;
        return;
      end
      byteValid = 1'b1;
      byteIn    = data[8*k +: 8];
      if (inj == 1 && k == 2) start = 1'b1;
      if (k == 3) begin
        sb.push_back({addr, data});
        exp_strobes++;
      end
      @(negedge clock);
      start = 1'b0;
      if (k == 3) begin
        byteValid = 1'b0;
        chk("latency_we", writeEnable, 1);
        chk("write_ready", byteReady, 0);
        if (inj == 2) begin
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
        end
      end else if (gap > 0) begin
        byteValid = 1'b0;
        repeat (gap) @(negedge clock);
      end
    end
    byteValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    repeat (2) @(negedge clock);
    check_reset_vals();
    reset = 1'b0;

    // byteValid in IDLE must be ignored
    byteValid = 1'b1;
    byteIn    = 8'hFF;
    repeat (3) begin
      @(negedge clock);
      chk("idle_ready", byteReady, 0);
    end
    byteValid = 1'b0;

    // Single-word smoke test, then abandon via reset
    pulse_start();
    send_word(32'h00080013, 32'd0, 0, 0, 4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_vals();

    // Full gap-free session with ignored start pulses in LOAD and WRITE
    pulse_start();
    for (int i = 0; i < WORDS; i++) begin
      send_word(32'hA5000000 + 32'(i), 32'(i * 4), 0,
                (i == 3) ? 1 : ((i == 7) ? 2 : 0), 4);
    end
    @(negedge clock);
    chk("done_flag",   done, 1);
    chk("done_count",  wordCount, 32);
    chk("done_ready",  byteReady, 0);
    chk("done_busy",   busy, 0);
    chk("hold_addr",   writeAddress, 124);
    chk("hold_data",   writeData, 32'hA500001F);

    // byteValid in DONE must be ignored
    byteValid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("done_ready_hold", byteReady, 0);
      chk("done_stays",      done, 1);
    end
    byteValid = 1'b0;

    // Start in DONE opens a new session; 3-cycle gaps between bytes
    pulse_start();
    for (int i = 0; i < WORDS; i++) begin
      send_word(32'h12345678 + 32'(i) * 32'h01010101, 32'(i * 4), 3, 0, 4);
    end
    @(negedge clock);
    chk("gap_done",  done, 1);
    chk("gap_count", wordCount, 32);

    // Reset after two bytes of word 5
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send_word(32'hA5000000 + 32'(i), 32'(i * 4), 0, 0, 4);
    end
    send_word(32'hA5000005, 32'd20, 0, 0, 2);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check_reset_vals();
    repeat (3) @(negedge clock);
    pulse_start();
    send_word(32'hDEADBEEF, 32'd0, 0, 0, 4);
    repeat (4) @(negedge clock);
    chk("post_rst_count", wordCount, 1);

    chk("sb_empty",     sb.size(), 0);
    chk("strobe_count", n_strobes, exp_strobes);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter WORDS, default 32, meaning the number of 32-bit instruction words loaded per session (one per instruction-memory slot).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the width of writeAddress.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a load session; honoured only in IDLE or DONE.
REQ-006 SHALL have port byteIn  input  8  incoming program byte, little-endian within each word.
REQ-007 SHALL have port byteValid  input  1  byteIn holds a valid byte.
REQ-008 SHALL have port byteReady  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port writeAddress  output  ADDR_W  byte address of the word being written, always wordIndex*4.
REQ-010 SHALL have port writeData  output  32  assembled instruction word.
REQ-011 SHALL have port writeEnable  output  1  one-cycle write strobe to the instruction memory.
REQ-012 SHALL have port busy  output  1  high in LOAD and WRITE.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port wordCount  output  clog2(WORDS)+1  number of words written in the current session.

Function
REQ-015 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: on start go to LOAD next cycle with byteIndex=0, wordIndex=0, wordCount=0; otherwise stay.
REQ-017 LOAD: byteReady=1; a byte is accepted only on a cycle with byteValid=1 and byteReady=1.
REQ-018 The k-th accepted byte of a word (k=0..3) SHALL be placed in writeData bits [8k+7:8k]; byteIndex increments by one per accepted byte.
REQ-019 Accepting byte k=3 SHALL move to WRITE on the next cycle and wrap byteIndex to 0.
REQ-020 WRITE: writeEnable=1 for exactly one cycle; writeAddress=wordIndex*4; writeData is the complete word; byteReady=0.
REQ-021 Leaving WRITE SHALL increment wordIndex and wordCount; if wordIndex was WORDS-1, go to DONE, else go to LOAD.
REQ-022 Latency: a byte 3 accepted in cycle N SHALL produce writeEnable in cycle N+1; peak throughput is one word per 5 cycles.
REQ-023 DONE: done=1 and byteReady=0 until start; start in DONE SHALL behave as start in IDLE.
REQ-024 start SHALL be ignored in LOAD and WRITE; byteValid SHALL be ignored outside LOAD.
REQ-025 byteValid gaps SHALL stall assembly without losing partially assembled bytes.
REQ-026 writeAddress and writeData SHALL hold their last values outside WRITE; writeEnable SHALL be 0 outside WRITE.

Reset
REQ-027 With reset high at a clock edge: state=IDLE, byteIndex=0, wordIndex=0, wordCount=0, writeData=0, writeAddress=0, writeEnable=0, byteReady=0, busy=0, done=0.
REQ-028 Reset asserted mid-session (in any state) SHALL abandon the session with no further writeEnable pulse; reset SHALL take priority over start.

Structure
REQ-029 A shared package instr_loader_pkg SHALL hold the state enumeration, BYTES_PER_WORD=4, and the default WORDS=32.
REQ-030 One sub-module, word_assembler (byte shift-in with byteIndex counter and a word-complete flag), is natural; the FSM and word counters remain in instr_loader.

Verification
REQ-031 After reset, pulse start, then stream bytes 13,00,08,00 back-to-back -> one writeEnable with writeAddress=0 and writeData=32'h00080013, one cycle after the 4th byte.
REQ-032 Load WORDS=32 words with word i = 32'hA5000000+i -> 32 strobes, addresses 0,4,...,124, then done=1, wordCount=32, byteReady=0.
REQ-033 Insert 3-cycle byteValid gaps between every byte -> same writeData as the gap-free case; no extra or missing strobes.
REQ-034 Assert reset after 2 bytes of word 5 -> all outputs at reset values the next cycle; a following start rewrites from writeAddress=0.
REQ-035 Pulse start during LOAD and during WRITE -> no effect on byteIndex, wordIndex or addresses; pulse start in DONE -> new session at address 0.
REQ-036 Drive byteValid=1 in IDLE and DONE -> byteReady=0, writeEnable never asserted.
